// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared widths, opcode and state types for the SPI RAM
//                arbiter, plus the opcode-to-next-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_e;

    // Where the arbiter goes after forwarding a word: address words hold the
    // lock so the following data word cannot be interleaved by the other side.
    function automatic arb_state_e op_next_state(ram_op_e op);
        case (op)
            WR_ADDR, RD_ADDR: return LOCKED;
            WR_DATA:          return IDLE;
            default:          return WAIT_RD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-request round-robin arbiter. A lone request wins
//                outright; on contention ptr selects the winner. One-hot gnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] gnt
);

    // Grant the sole requester, or the pointed-to one when both ask.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_arbiter
//  Description : Shares the single-port SPI RAM between the SPI slave (req0)
//                and a host/debug port (req1). Address+data pairs are kept
//                together and read data is routed back to the issuer.
//                Optional read timeout: define SPI_RAM_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int RD_TIMEOUT = 8,
    parameter int RR_INIT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [CMD_W-1:0]  req0_din,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_dout,
    output logic              req0_tx_valid,
    input  logic              req1_valid,
    input  logic [CMD_W-1:0]  req1_din,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_dout,
    output logic              req1_tx_valid,
    output logic [CMD_W-1:0]  ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output logic              busy
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    ,
    output logic              rd_timeout
`endif
);

    localparam logic c_RR_INIT = 1'(RR_INIT);

    if (RD_TIMEOUT < 1 || RD_TIMEOUT > 256) begin : g_bad_rd_timeout
        $error("RD_TIMEOUT must be in 1..256");
    end

    arb_state_e         r_state;
    logic               r_owner;
    logic               r_rr;
    logic [1:0]         w_gnt;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_acc;
    logic [CMD_W-1:0]   w_word;
    ram_op_e            w_op;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(RD_TIMEOUT - 1);
    logic [7:0]         r_to_cnt;
`endif

    // Contention is only resolved in IDLE; a held lock bypasses the arbiter.
    rr_arb2 u_rr_arb2 (
        .req    ({req1_valid, req0_valid}),
        .ptr    (r_rr),
        .enable (r_state == IDLE),
        .gnt    (w_gnt)
    );

    // Ready decode: arbiter result in IDLE, owner only while locked, none in WAIT_RD.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_gnt[0];
                req1_ready = w_gnt[1];
            end
            LOCKED: begin
                req0_ready = ~r_owner;
                req1_ready =  r_owner;
            end
            default: ;
        endcase
    end

    assign w_acc0 = req0_valid & req0_ready;
    assign w_acc1 = req1_valid & req1_ready;
    assign w_acc  = w_acc0 | w_acc1;
    assign w_word = w_acc1 ? req1_din : req0_din;
    assign w_op   = ram_op_e'(w_word[CMD_W-1:CMD_W-2]);
    assign busy   = (r_state != IDLE);

    // Arbitration FSM, registered word forwarding and read-data return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_rr          <= c_RR_INIT;
            ram_din       <= '0;
            ram_rx_valid  <= 1'b0;
            req0_dout     <= '0;
            req1_dout     <= '0;
            req0_tx_valid <= 1'b0;
            req1_tx_valid <= 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            r_to_cnt      <= '0;
            rd_timeout    <= 1'b0;
`endif
        end else begin
            ram_rx_valid  <= w_acc;
            req0_tx_valid <= 1'b0;
            req1_tx_valid <= 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            rd_timeout    <= 1'b0;
`endif
            if (w_acc) begin
                ram_din <= w_word;
            end
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_owner <= w_acc1;
                        r_rr    <= ~w_acc1;
                        r_state <= op_next_state(w_op);
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (w_acc) begin
                        r_state <= op_next_state(w_op);
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                WAIT_RD: begin
                    // Data arriving on the expiry cycle still wins over the timeout.
                    if (ram_tx_valid) begin
                        if (r_owner) begin
                            req1_dout     <= ram_dout;
                            req1_tx_valid <= 1'b1;
                        end else begin
                            req0_dout     <= ram_dout;
                            req0_tx_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_LAST) begin
                        rd_timeout <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_arbiter
//  Description : Directed self-checking bench for spi_ram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid;
    logic [9:0] req0_din;
    logic       req0_ready;
    logic [7:0] req0_dout;
    logic       req0_tx_valid;
    logic       req1_valid;
    logic [9:0] req1_din;
    logic       req1_ready;
    logic [7:0] req1_dout;
    logic       req1_tx_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       busy;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    logic       rd_timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spi_ram_arbiter #(
        .RD_TIMEOUT (8),
        .RR_INIT    (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_din      (req0_din),
        .req0_ready    (req0_ready),
        .req0_dout     (req0_dout),
        .req0_tx_valid (req0_tx_valid),
        .req1_valid    (req1_valid),
        .req1_din      (req1_din),
        .req1_ready    (req1_ready),
        .req1_dout     (req1_dout),
        .req1_tx_valid (req1_tx_valid),
        .ram_din       (ram_din),
        .ram_rx_valid  (ram_rx_valid),
        .ram_dout      (ram_dout),
        .ram_tx_valid  (ram_tx_valid),
        .busy          (busy)
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        ,
        .rd_timeout    (rd_timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        req0_valid   = 1'b0;
        req0_din     = '0;
        req1_valid   = 1'b0;
        req1_din     = '0;
        ram_dout     = '0;
        ram_tx_valid = 1'b0;
        repeat (3) step();

        // Reset state
        check_eq("rst_ram_din", 16'(ram_din), 16'h000);
        check_eq("rst_rx_valid", 16'(ram_rx_valid), 16'h0);
        check_eq("rst_req0_dout", 16'(req0_dout), 16'h00);
        check_eq("rst_req1_dout", 16'(req1_dout), 16'h00);
        check_eq("rst_tx_valids", 16'({req0_tx_valid, req1_tx_valid}), 16'h0);
        check_eq("rst_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;

        // Address+data pair from req0 while req1 waits
        req0_valid = 1'b1; req0_din = 10'h005;
        req1_valid = 1'b1; req1_din = 10'h007;
        #1;
        check_eq("pair_rdy_a", 16'({req1_ready, req0_ready}), 16'b01);
        step();
        check_eq("pair_din_a", 16'(ram_din), 16'h005);
        check_eq("pair_rxv_a", 16'(ram_rx_valid), 16'h1);
        check_eq("pair_busy", 16'(busy), 16'h1);
        req0_din = 10'h1AA;
        #1;
        check_eq("pair_rdy_d", 16'({req1_ready, req0_ready}), 16'b01);
        step();
        check_eq("pair_din_d", 16'(ram_din), 16'h1AA);
        req0_valid = 1'b0;
        #1;
        check_eq("pair_rdy_r1", 16'({req1_ready, req0_ready}), 16'b10);
        step();
        check_eq("pair_din_r1", 16'(ram_din), 16'h007);
        check_eq("pair_rxv_r1", 16'(ram_rx_valid), 16'h1);

        // Read by req1 (already holding the lock from 0x007)
        req1_din = 10'h205;
        #1;
        check_eq("rd_rdy_addr", 16'(req1_ready), 16'h1);
        step();
        check_eq("rd_din_addr", 16'(ram_din), 16'h205);
        req1_din = 10'h300;
        step();
        check_eq("rd_din_data", 16'(ram_din), 16'h300);
        req1_valid = 1'b0;
        step();
        check_eq("rd_rxv_idle", 16'(ram_rx_valid), 16'h0);
        check_eq("rd_rdy_wait", 16'({req1_ready, req0_ready}), 16'b00);
        check_eq("rd_tx_early", 16'({req1_tx_valid, req0_tx_valid}), 16'b00);
        ram_tx_valid = 1'b1; ram_dout = 8'hAA;
        step();
        ram_tx_valid = 1'b0;
        check_eq("rd_tx_pulse", 16'({req1_tx_valid, req0_tx_valid}), 16'b10);
        check_eq("rd_req1_dout", 16'(req1_dout), 16'h0AA);
        check_eq("rd_req0_dout", 16'(req0_dout), 16'h000);
        check_eq("rd_busy_done", 16'(busy), 16'h0);
        step();
        check_eq("rd_tx_end", 16'({req1_tx_valid, req0_tx_valid}), 16'b00);
        check_eq("rd_dout_hold", 16'(req1_dout), 16'h0AA);

        // Round-robin alternation with single WR_DATA words
        req0_valid = 1'b1; req0_din = 10'h111;
        req1_valid = 1'b1; req1_din = 10'h122;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_rdy_%0d", i), 16'({req1_ready, req0_ready}),
                     (i % 2 == 0) ? 16'b01 : 16'b10);
            step();
            check_eq($sformatf("rr_din_%0d", i), 16'(ram_din),
                     (i % 2 == 0) ? 16'h111 : 16'h122);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Stray RAM data in IDLE is ignored
        ram_tx_valid = 1'b1; ram_dout = 8'h55;
        step();
        ram_tx_valid = 1'b0;
        check_eq("stray_tx", 16'({req1_tx_valid, req0_tx_valid}), 16'b00);
        check_eq("stray_req0_dout", 16'(req0_dout), 16'h00);
        check_eq("stray_req1_dout", 16'(req1_dout), 16'hAA);

        // Reset while waiting on a read
        req0_valid = 1'b1; req0_din = 10'h300;
        step();
        req0_valid = 1'b0;
        check_eq("rstw_busy", 16'(busy), 16'h1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_busy0", 16'(busy), 16'h0);
        check_eq("rstw_ram_din", 16'(ram_din), 16'h000);
        check_eq("rstw_req1_dout", 16'(req1_dout), 16'h00);
        check_eq("rstw_rxv", 16'(ram_rx_valid), 16'h0);
        step();
        rst_n = 1'b1;
        ram_tx_valid = 1'b1; ram_dout = 8'h77;
        step();
        ram_tx_valid = 1'b0;
        check_eq("rstw_late_tx", 16'({req1_tx_valid, req0_tx_valid}), 16'b00);
        check_eq("rstw_late_dout", 16'(req0_dout), 16'h00);

`ifdef SPI_RAM_ARB_TIMEOUT_EN
        // Read timeout: RAM never answers
        req0_valid = 1'b1; req0_din = 10'h300;
        step();
        req0_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step();
            check_eq($sformatf("to_quiet_%0d", k), 16'(rd_timeout), 16'h0);
        end
        step();
        check_eq("to_pulse", 16'(rd_timeout), 16'h1);
        check_eq("to_busy", 16'(busy), 16'h0);
        check_eq("to_no_tx", 16'({req1_tx_valid, req0_tx_valid}), 16'b00);
        req1_valid = 1'b1; req1_din = 10'h1C3;
        #1;
        check_eq("to_new_rdy", 16'(req1_ready), 16'h1);
        step();
        req1_valid = 1'b0;
        check_eq("to_new_din", 16'(ram_din), 16'h1C3);
        check_eq("to_pulse_end", 16'(rd_timeout), 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Both readies must never be high together.
    always @(negedge clk) begin
        if (rst_n && req0_ready && req1_ready) begin
            check_eq("both_ready", 16'({req1_ready, req0_ready}), 16'b00);
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port SPI RAM between two command requesters: req0 is the SPI slave, req1 is a host/debug port.
- Requesters issue 10-bit command words (bits[9:8] opcode, bits[7:0] payload) through valid/ready.
- The arbiter serialises the words onto the RAM din/rx_valid input. An address+data pair is never split between requesters.
- Read data returned on RAM dout/tx_valid is routed back to the requester that issued the read.

Parameters:
- RD_TIMEOUT, 8, cycles to wait for ram_tx_valid after forwarding RD_DATA (used only with SPI_RAM_ARB_TIMEOUT_EN).
- RR_INIT, 0, requester that holds priority first after reset (0 or 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 command word valid
- req0_din  in  10  requester 0 command word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- req0_dout  out  8  read data to requester 0
- req0_tx_valid  out  1  one-cycle pulse, req0_dout valid
- req1_valid, req1_din, req1_ready, req1_dout, req1_tx_valid: same as req0, for requester 1
- ram_din  out  10  command word to RAM
- ram_rx_valid  out  1  one-cycle pulse, ram_din valid
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- busy  out  1  high while LOCKED or WAIT_RD

Behaviour:
- Reset values:
  - ram_din=0, ram_rx_valid=0.
  - reqN_dout=0, reqN_tx_valid=0.
  - busy=0; state=IDLE; rr pointer=RR_INIT; owner=0.
- Opcodes: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
- Forwarding is registered: a word accepted at edge T appears on ram_din with ram_rx_valid=1 for exactly one cycle after T. At most one word is forwarded per cycle.
- reqN_ready is combinational from state, owner and the arbitration result. It is never high for both requesters at once.
- IDLE:
  - Only one valid: that requester gets ready.
  - Both valid: the requester pointed to by the rr pointer gets ready.
  - On acceptance: owner←winner, rr pointer←other requester.
  - Accepted WR_ADDR or RD_ADDR → LOCKED.
  - Accepted WR_DATA → stay IDLE (single-word write at the RAM's latched address).
  - Accepted RD_DATA → WAIT_RD.
- LOCKED:
  - Only the owner gets ready; the other requester stalls.
  - Owner WR_ADDR or RD_ADDR → forwarded, stay LOCKED.
  - Owner WR_DATA → forwarded, go to IDLE.
  - Owner RD_DATA → forwarded, go to WAIT_RD.
- WAIT_RD:
  - Both readies low.
  - When ram_tx_valid=1: register ram_dout onto owner's reqN_dout, pulse owner's reqN_tx_valid for 1 cycle, go to IDLE.
  - The non-owner reqN_dout holds its old value.
- ram_tx_valid outside WAIT_RD is ignored; no pulse is generated.
- Read latency: RD_DATA accepted at T → ram_rx_valid at T+1 → RAM tx_valid at T+2 → reqN_tx_valid at T+3.
- busy=1 in LOCKED and WAIT_RD.
- Reset asserted mid-operation: immediate return to reset values. The lock is dropped, any pending read is discarded, and no tx_valid pulse is emitted.

Optional Feature:
- SPI_RAM_ARB_TIMEOUT_EN defined:
  - Adds output port rd_timeout (1 bit, reset 0).
  - An 8-bit counter, cleared on entering WAIT_RD, counts cycles.
  - At RD_TIMEOUT cycles without ram_tx_valid: pulse rd_timeout for 1 cycle, go to IDLE, no reqN_tx_valid.
  - If ram_tx_valid and expiry occur in the same cycle, data wins and there is no timeout pulse.
- Undefined: no port and no counter; WAIT_RD waits indefinitely.

Decomposition:
- Package spi_ram_pkg:
  - CMD_W=10, DATA_W=8.
  - enum ram_op_e {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} (2 bits).
  - enum arb_state_e {IDLE, LOCKED, WAIT_RD}.
- Sub-module rr_arb2: two-request round-robin arbiter. Inputs: req[1:0], ptr, enable. Output: one-hot gnt.

Test Plan:
- req0 sends 0x005 (WR_ADDR 5) then 0x1AA (WR_DATA 0xAA); req1 holds valid on 0x007 throughout → ram_din sequence 0x005, 0x1AA, then 0x007. req1_ready stays low until the pair completes.
- req1 sends 0x205 (RD_ADDR 5) then 0x300 (RD_DATA), with RAM returning 0xAA → req1_tx_valid pulses 3 cycles after RD_DATA acceptance with req1_dout=0xAA. req0_tx_valid stays 0.
- Both requesters assert valid in IDLE every cycle with single WR_DATA words, RR_INIT=0 → grants alternate 0,1,0,1. No cycle has both readies high.
- Stray ram_tx_valid in IDLE with ram_dout=0x55 → no reqN_tx_valid; req0_dout and req1_dout unchanged.
- rst_n pulsed low while in WAIT_RD → all outputs return to 0 asynchronously. A late ram_tx_valid after reset produces no pulse.
- With SPI_RAM_ARB_TIMEOUT_EN and RD_TIMEOUT=8: RD_DATA forwarded, RAM never responds → rd_timeout pulses 8 cycles after entering WAIT_RD, then state is IDLE and a new request is accepted the next cycle.
